ifm_chunk_packer: RTL and testbench

Write-side producer for the double-buffered IFM sparse data chunk store. It accepts dense IFM beats over a valid/ready stream and converts each beat to a sparsemap plus nonzero bytes compacted toward byte 0. It drives the store's write port (`wr_sparsemap`, `wr_nonzero_data`, `wr_valid`, `wr_count`, `wr_sel`) and owns ping-pong buffer ownership. A buffer is handed to the compute-side reader once full and is reclaimed on the reader's release.

---
 rtl/ifm_chunk_packer_pkg.sv | 10 +
 rtl/ifm_chunk_packer_if.sv | 43 ++++
 rtl/ifm_chunk_packer_beat_compactor.sv | 49 ++++
 rtl/ifm_chunk_packer.sv | 132 +++++++++++++
 tb/tb_ifm_chunk_packer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifm_chunk_packer_pkg.sv
// Shared types and default geometry for the IFM sparse chunk store and its producer.
package ifm_pkg;

  localparam int IFM_MEM_SIZE = 128;
  localparam int IFM_BUS_SIZE = 16;

  typedef logic [7:0] byte_t;
  typedef byte_t [IFM_BUS_SIZE-1:0] beat_t;

endpackage

// File: rtl/ifm_chunk_packer_if.sv
// Packer-facing bundle: dense input stream, store write port and reader handoff.
// master = packer side, slave = environment side. chunk_nnz_o exists only with IFM_CHUNK_NNZ_EN.
interface ifm_chunk_packer_if #(
  parameter int MEM_SIZE = ifm_pkg::IFM_MEM_SIZE,
  parameter int BUS_SIZE = ifm_pkg::IFM_BUS_SIZE
);
  localparam int BEATS = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W = $clog2(BEATS);

  logic [BUS_SIZE-1:0][7:0] in_data_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [BUS_SIZE-1:0]      wr_sparsemap_o;
  logic [BUS_SIZE-1:0][7:0] wr_nonzero_data_o;
  logic                     wr_valid_o;
  logic [CNT_W-1:0]         wr_count_o;
  logic                     wr_sel_o;
  logic                     rd_sel_o;
  logic                     chunk_ready_o;
  logic                     rd_done_i;
`ifdef IFM_CHUNK_NNZ_EN
  logic [$clog2(MEM_SIZE):0] chunk_nnz_o;
`endif

  modport master (
    input  in_data_i, in_valid_i, rd_done_i,
    output in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o, wr_count_o, wr_sel_o,
`ifdef IFM_CHUNK_NNZ_EN
    output chunk_nnz_o,
`endif
    output rd_sel_o, chunk_ready_o
  );

  modport slave (
    output in_data_i, in_valid_i, rd_done_i,
    input  in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o, wr_count_o, wr_sel_o,
`ifdef IFM_CHUNK_NNZ_EN
    input  chunk_nnz_o,
`endif
    input  rd_sel_o, chunk_ready_o
  );

endinterface

// File: rtl/ifm_chunk_packer_beat_compactor.sv
// Combinational beat compactor: sparsemap plus nonzero bytes packed toward byte 0.
// o_popcount exists only with IFM_CHUNK_NNZ_EN.
module ifm_beat_compactor
  import ifm_pkg::*;
#(
  parameter int BUS_SIZE = IFM_BUS_SIZE
) (
  input  byte_t [BUS_SIZE-1:0]            i_beat,
  output logic  [BUS_SIZE-1:0]            o_sparsemap,
  output logic  [BUS_SIZE-1:0][7:0]       o_data
`ifdef IFM_CHUNK_NNZ_EN
  , output logic [$clog2(BUS_SIZE+1)-1:0] o_popcount
`endif
);

  localparam int POP_W = $clog2(BUS_SIZE + 1);

  logic [BUS_SIZE-1:0] w_nz;
  logic [POP_W-1:0]    w_pos [BUS_SIZE];
  logic [POP_W-1:0]    w_run;

  // w_pos[i] is the exclusive prefix count of nonzero bytes, i.e. byte i's output slot.
  always_comb begin
    w_run = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      w_nz[i]  = |i_beat[i];
      w_pos[i] = w_run;
      w_run    = w_run + POP_W'(w_nz[i]);
    end
  end

  // A byte can only move down, so slot j only needs to look at bytes j and above.
  always_comb begin
    for (int j = 0; j < BUS_SIZE; j++) begin
      o_data[j] = '0;
      for (int i = j; i < BUS_SIZE; i++) begin
        if (w_nz[i] && (w_pos[i] == POP_W'(j))) begin
          o_data[j] = o_data[j] | i_beat[i];
        end
      end
    end
  end

  assign o_sparsemap = w_nz;
`ifdef IFM_CHUNK_NNZ_EN
  assign o_popcount  = w_run;
`endif

endmodule

// File: rtl/ifm_chunk_packer.sv
// Write-side producer for the ping-pong IFM sparse chunk store; owns buffer full flags.
// Optional per-chunk nonzero count output is enabled by IFM_CHUNK_NNZ_EN.
module ifm_chunk_packer
  import ifm_pkg::*;
#(
  parameter int MEM_SIZE = IFM_MEM_SIZE,
  parameter int BUS_SIZE = IFM_BUS_SIZE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ifm_chunk_packer_if.master  bus
);

  localparam int BEATS = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [BUS_SIZE-1:0]      w_sparsemap;
  logic [BUS_SIZE-1:0][7:0] w_data;
  logic                     w_accept;
  logic                     w_set;
  logic                     w_clr;
  logic [1:0]               w_set_vec;
  logic [1:0]               w_clr_vec;

  logic [1:0]               r_full;
  logic                     r_in_sel;
  logic [CNT_W-1:0]         r_in_cnt;
  logic                     r_rd_sel;
  logic [BUS_SIZE-1:0]      r_wr_sparsemap;
  logic [BUS_SIZE-1:0][7:0] r_wr_data;
  logic                     r_wr_valid;
  logic [CNT_W-1:0]         r_wr_count;
  logic                     r_wr_sel;

`ifdef IFM_CHUNK_NNZ_EN
  localparam int POP_W = $clog2(BUS_SIZE + 1);
  localparam int NNZ_W = $clog2(MEM_SIZE) + 1;
  logic [POP_W-1:0] w_popcount;
  logic [POP_W-1:0] r_wr_pop;
  logic [NNZ_W-1:0] r_nnz_acc;
  logic [NNZ_W-1:0] r_chunk_nnz;
`endif

  ifm_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
    .i_beat      (bus.in_data_i),
    .o_sparsemap (w_sparsemap),
    .o_data      (w_data)
`ifdef IFM_CHUNK_NNZ_EN
    , .o_popcount(w_popcount)
`endif
  );

  assign bus.in_ready_o = rst_i && !r_full[r_in_sel];
  assign w_accept       = bus.in_valid_i && bus.in_ready_o;

  // Full is raised one cycle after the last beat is presented, so the store has captured it.
  assign w_set     = r_wr_valid && (r_wr_count == LAST_CNT);
  assign w_clr     = bus.rd_done_i && r_full[r_rd_sel];
  assign w_set_vec = {w_set && r_wr_sel, w_set && !r_wr_sel};
  assign w_clr_vec = {w_clr && r_rd_sel, w_clr && !r_rd_sel};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_in_sel       <= 1'b0;
      r_in_cnt       <= '0;
      r_wr_sparsemap <= '0;
      r_wr_data      <= '0;
      r_wr_valid     <= 1'b0;
      r_wr_count     <= '0;
      r_wr_sel       <= 1'b0;
    end else begin
      r_wr_valid <= w_accept;
      if (w_accept) begin
        r_wr_sparsemap <= w_sparsemap;
        r_wr_data      <= w_data;
        r_wr_count     <= r_in_cnt;
        r_wr_sel       <= r_in_sel;
        r_in_cnt       <= r_in_cnt + CNT_W'(1);
        if (r_in_cnt == LAST_CNT) begin
          r_in_sel <= ~r_in_sel;
        end
      end
    end
  end

  // Set and clear always target different buffers, so both can apply in one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_full   <= 2'b00;
      r_rd_sel <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_clr_vec) | w_set_vec;
      if (w_clr) begin
        r_rd_sel <= ~r_rd_sel;
      end
    end
  end

`ifdef IFM_CHUNK_NNZ_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_pop    <= '0;
      r_nnz_acc   <= '0;
      r_chunk_nnz <= '0;
    end else begin
      if (w_accept) begin
        r_wr_pop <= w_popcount;
      end
      if (r_wr_valid) begin
        if (r_wr_count == LAST_CNT) begin
          r_chunk_nnz <= r_nnz_acc + NNZ_W'(r_wr_pop);
          r_nnz_acc   <= '0;
        end else begin
          r_nnz_acc   <= r_nnz_acc + NNZ_W'(r_wr_pop);
        end
      end
    end
  end

  assign bus.chunk_nnz_o = r_chunk_nnz;
`endif

  assign bus.wr_sparsemap_o    = r_wr_sparsemap;
  assign bus.wr_nonzero_data_o = r_wr_data;
  assign bus.wr_valid_o        = r_wr_valid;
  assign bus.wr_count_o        = r_wr_count;
  assign bus.wr_sel_o          = r_wr_sel;
  assign bus.rd_sel_o          = r_rd_sel;
  assign bus.chunk_ready_o     = r_full[r_rd_sel];

endmodule

// File: tb/tb_ifm_chunk_packer.sv
// Directed bench for ifm_chunk_packer: compaction table, ping-pong stall/release, mid-chunk reset.
// Chunk nonzero-count checks are compiled in with IFM_CHUNK_NNZ_EN.
module tb_ifm_chunk_packer;

  localparam int MEM_SIZE = 128;
  localparam int BUS_SIZE = 16;
  localparam int BEATS    = 8;

  typedef logic [BUS_SIZE-1:0][7:0] beat_vec_t;

  typedef struct {
    beat_vec_t           beat;
    logic [BUS_SIZE-1:0] expMap;
    beat_vec_t           expData;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  vec_t      vecs [BEATS];
  beat_vec_t beat17;
  beat_vec_t exp17;
  beat_vec_t nnzBeat;
  beat_vec_t nnzExp;

  always #5 clk = ~clk;

  ifm_chunk_packer_if #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE)) bus ();

  ifm_chunk_packer #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input beat_vec_t beat, input logic done);
    bus.in_valid_i = valid;
    bus.in_data_i  = beat;
    bus.rd_done_i  = done;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [BUS_SIZE-1:0] expMap,
                            input beat_vec_t expData, input int expCount, input logic expSel);
    checkOutput({tag, ".valid"}, bus.wr_valid_o, 1'b1);
    checkOutput({tag, ".map"},   bus.wr_sparsemap_o, expMap);
    checkOutput({tag, ".data"},  bus.wr_nonzero_data_o, expData);
    checkOutput({tag, ".count"}, bus.wr_count_o, expCount[2:0]);
    checkOutput({tag, ".sel"},   bus.wr_sel_o, expSel);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Hand-computed compaction vectors, applied back-to-back as chunk 0.
    for (int k = 0; k < BEATS; k++) begin
      vecs[k].beat    = '0;
      vecs[k].expMap  = '0;
      vecs[k].expData = '0;
    end
    vecs[0].beat[2] = 8'h11; vecs[0].beat[9] = 8'h22;
    vecs[0].expMap  = 16'h0204;
    vecs[0].expData[0] = 8'h11; vecs[0].expData[1] = 8'h22;
    for (int i = 0; i < BUS_SIZE; i++) begin
      vecs[2].beat[i]    = 8'(i + 1);
      vecs[2].expData[i] = 8'(i + 1);
    end
    vecs[2].expMap = 16'hFFFF;
    vecs[3].beat[15] = 8'h80; vecs[3].expMap = 16'h8000; vecs[3].expData[0] = 8'h80;
    vecs[4].beat[0] = 8'h01; vecs[4].beat[15] = 8'h02; vecs[4].expMap = 16'h8001;
    vecs[4].expData[0] = 8'h01; vecs[4].expData[1] = 8'h02;
    for (int j = 0; j < BUS_SIZE / 2; j++) begin
      vecs[5].beat[2*j+1] = 8'hA0 + 8'(2*j + 1);
      vecs[5].expData[j]  = 8'hA0 + 8'(2*j + 1);
    end
    vecs[5].expMap = 16'hAAAA;
    vecs[6].beat[0] = 8'h5A; vecs[6].expMap = 16'h0001; vecs[6].expData[0] = 8'h5A;
    vecs[7].beat[3] = 8'h33; vecs[7].beat[4] = 8'h44; vecs[7].beat[5] = 8'h55;
    vecs[7].expMap = 16'h0038;
    vecs[7].expData[0] = 8'h33; vecs[7].expData[1] = 8'h44; vecs[7].expData[2] = 8'h55;

    beat17 = '0; beat17[7] = 8'h77;
    exp17  = '0; exp17[0]  = 8'h77;
    nnzBeat = '0; nnzBeat[0] = 8'h01; nnzBeat[5] = 8'h02; nnzBeat[10] = 8'h03;
    nnzExp  = '0; nnzExp[0]  = 8'h01; nnzExp[1]  = 8'h02; nnzExp[2]   = 8'h03;

    // Reset and idle state.
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_ready_in_reset", bus.in_ready_o, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst.in_ready",    bus.in_ready_o, 1'b1);
    checkOutput("rst.chunk_ready", bus.chunk_ready_o, 1'b0);
    checkOutput("rst.rd_sel",      bus.rd_sel_o, 1'b0);
    checkOutput("rst.wr_valid",    bus.wr_valid_o, 1'b0);
    checkOutput("rst.wr_map",      bus.wr_sparsemap_o, '0);
    checkOutput("rst.wr_data",     bus.wr_nonzero_data_o, '0);
    checkOutput("rst.wr_count",    bus.wr_count_o, '0);
    checkOutput("rst.wr_sel",      bus.wr_sel_o, 1'b0);
`ifdef IFM_CHUNK_NNZ_EN
    checkOutput("rst.chunk_nnz",   bus.chunk_nnz_o, '0);
`endif

    // Chunk 0 from the table, back-to-back.
    for (int k = 0; k < BEATS; k++) begin
      applyStimulus(1'b1, vecs[k].beat, 1'b0);
      tick();
      checkWrite($sformatf("c0b%0d", k), vecs[k].expMap, vecs[k].expData, k, 1'b0);
      checkOutput($sformatf("c0b%0d.chunk_ready", k), bus.chunk_ready_o, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    checkOutput("c0.done.wr_valid",    bus.wr_valid_o, 1'b0);
    checkOutput("c0.done.count_hold",  bus.wr_count_o, 3'd7);
    checkOutput("c0.done.chunk_ready", bus.chunk_ready_o, 1'b1);
    checkOutput("c0.done.rd_sel",      bus.rd_sel_o, 1'b0);

    // Chunk 1 fills the other buffer; afterwards the producer must stall.
    for (int k = 0; k < BEATS; k++) begin
      checkOutput($sformatf("c1b%0d.in_ready", k), bus.in_ready_o, 1'b1);
      applyStimulus(1'b1, vecs[k].beat, 1'b0);
      tick();
      checkWrite($sformatf("c1b%0d", k), vecs[k].expMap, vecs[k].expData, k, 1'b1);
    end
    checkOutput("stall.in_ready_drop", bus.in_ready_o, 1'b0);
    applyStimulus(1'b1, beat17, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput($sformatf("stall%0d.wr_valid", n), bus.wr_valid_o, 1'b0);
      checkOutput($sformatf("stall%0d.in_ready", n), bus.in_ready_o, 1'b0);
    end
    checkOutput("stall.chunk_ready", bus.chunk_ready_o, 1'b1);
    checkOutput("stall.rd_sel",      bus.rd_sel_o, 1'b0);

    // Reader releases buffer 0 while the 17th beat is held.
    applyStimulus(1'b1, beat17, 1'b1);
    tick();
    applyStimulus(1'b1, beat17, 1'b0);
    checkOutput("release.in_ready",    bus.in_ready_o, 1'b1);
    checkOutput("release.rd_sel",      bus.rd_sel_o, 1'b1);
    checkOutput("release.chunk_ready", bus.chunk_ready_o, 1'b1);
    checkOutput("release.wr_valid",    bus.wr_valid_o, 1'b0);
    tick();
    checkWrite("beat17", 16'h0080, exp17, 0, 1'b0);

    // Four more beats into buffer 0, then reset mid-chunk.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, vecs[k].beat, 1'b0);
      tick();
      checkWrite($sformatf("part%0d", k), vecs[k].expMap, vecs[k].expData, k + 1, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.wr_valid",    bus.wr_valid_o, 1'b0);
    checkOutput("midrst.wr_count",    bus.wr_count_o, '0);
    checkOutput("midrst.wr_map",      bus.wr_sparsemap_o, '0);
    checkOutput("midrst.in_ready",    bus.in_ready_o, 1'b0);
    checkOutput("midrst.chunk_ready", bus.chunk_ready_o, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checkOutput("postrst.in_ready",    bus.in_ready_o, 1'b1);
    checkOutput("postrst.rd_sel",      bus.rd_sel_o, 1'b0);
    checkOutput("postrst.chunk_ready", bus.chunk_ready_o, 1'b0);

    // A release with nothing ready must be ignored.
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("idle_done.rd_sel",      bus.rd_sel_o, 1'b0);
    checkOutput("idle_done.chunk_ready", bus.chunk_ready_o, 1'b0);

    // Chunk A: three nonzero bytes per beat, starting fresh at buffer 0, count 0.
    for (int k = 0; k < BEATS; k++) begin
      applyStimulus(1'b1, nnzBeat, 1'b0);
      tick();
      checkWrite($sformatf("cA.b%0d", k), 16'h0421, nnzExp, k, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    checkOutput("cA.chunk_ready", bus.chunk_ready_o, 1'b1);
    checkOutput("cA.rd_sel",      bus.rd_sel_o, 1'b0);
`ifdef IFM_CHUNK_NNZ_EN
    checkOutput("cA.chunk_nnz",   bus.chunk_nnz_o, 24);
`endif

    // Chunk B: all-zero beats into buffer 1, which the reset must have emptied.
    for (int k = 0; k < BEATS; k++) begin
      checkOutput($sformatf("cB.b%0d.in_ready", k), bus.in_ready_o, 1'b1);
      applyStimulus(1'b1, '0, 1'b0);
      tick();
      checkWrite($sformatf("cB.b%0d", k), 16'h0000, '0, k, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick();
`ifdef IFM_CHUNK_NNZ_EN
    checkOutput("cB.chunk_nnz", bus.chunk_nnz_o, 0);
`endif
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("cB.release.rd_sel",      bus.rd_sel_o, 1'b1);
    checkOutput("cB.release.chunk_ready", bus.chunk_ready_o, 1'b1);
    checkOutput("cB.release.in_ready",    bus.in_ready_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
